// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks every register of a register bank two at a time. The even index is
// read on port 1 and the odd index on port 2. Each sampled pair is streamed to
// a downstream consumer over a valid/ready handshake.
// Each dump visits READ (one cycle, enables driven, buses sampled) and then
// HOLD (pair presented until accepted). After the last pair the FSM spends one
// DONE cycle and returns to IDLE.
// Optional feature: define REGDUMP_CHECKSUM_EN to build the running XOR
// checksum of all accepted pairs. Without it, checksum is tied to zero.
module regfile_dump_reader #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [NUM_REGS-1:0]   rd_en1,
    output logic [NUM_REGS-1:0]   rd_en2,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_STEP = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(NUM_REGS - 2);

    // One-hot decode of a register index into an enable vector.
    function automatic logic [NUM_REGS-1:0] one_hot(input logic [ADDR_WIDTH-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  start_ok_s;
    logic                  capture_s;

    logic [NUM_REGS-1:0]   rd_en1_r;
    logic [NUM_REGS-1:0]   rd_en2_r;
    logic                  out_valid_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic [DATA_WIDTH-1:0] out_data1_r;
    logic [DATA_WIDTH-1:0] out_data2_r;
    logic                  busy_r;
    logic                  done_r;

    // An abort in IDLE suppresses a simultaneous start. The read buses are
    // sampled only in a READ cycle that is not being aborted.
    always_comb begin
        start_ok_s = (state_r == ST_IDLE) && start && !abort;
        capture_s  = (state_r == ST_READ) && !abort;
    end

    // Next-state and index logic. Abort wins over the handshake.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_READ;
                    idx_s   = IDX_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (out_valid_r && out_ready) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_READ;
                        idx_s   = idx_r + IDX_STEP;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = IDX_ZERO;
            end
        endcase
    end

    // State and pair index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Control outputs are decoded from the next state, so each one is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en1_r    <= {NUM_REGS{1'b0}};
            rd_en2_r    <= {NUM_REGS{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (state_s == ST_READ) begin
                rd_en1_r <= one_hot(idx_s);
                rd_en2_r <= one_hot(idx_s + IDX_ONE);
            end else begin
                rd_en1_r <= {NUM_REGS{1'b0}};
                rd_en2_r <= {NUM_REGS{1'b0}};
            end
            out_valid_r <= (state_s == ST_HOLD);
            busy_r      <= (state_s == ST_READ) || (state_s == ST_HOLD);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Output pair capture. The pair stays stable through the whole HOLD stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_addr_r  <= IDX_ZERO;
            out_data1_r <= {DATA_WIDTH{1'b0}};
            out_data2_r <= {DATA_WIDTH{1'b0}};
        end else if (capture_s) begin
            out_addr_r  <= idx_r;
            out_data1_r <= rd_data1;
            out_data2_r <= rd_data2;
        end else begin
            out_addr_r  <= out_addr_r;
            out_data1_r <= out_data1_r;
            out_data2_r <= out_data2_r;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] checksum_r;

    // A pair counts only when it is handed over and no abort is in effect.
    always_comb begin
        accept_s = (state_r == ST_HOLD) && out_valid_r && out_ready && !abort;
    end

    // Running XOR of accepted pairs. It clears on start and is held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            checksum_r <= checksum_r ^ out_data1_r ^ out_data2_r;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = {DATA_WIDTH{1'b0}};
`endif

    assign rd_en1    = rd_en1_r;
    assign rd_en2    = rd_en2_r;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_data1 = out_data1_r;
    assign out_data2 = out_data2_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader. It models the register file and checks
// the streamed pairs against the expected dump sequence.
module tb_regfile_dump_reader;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NR-1:0] rd_en1;
    logic [NR-1:0] rd_en2;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data1;
    logic [DW-1:0] out_data2;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    regfile_dump_reader #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data1(out_data1), .out_data2(out_data2), .busy(busy), .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Register bank model. The read buses OR together every enabled register.
    logic [DW-1:0] regs [NR];
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int i = 0; i < NR; i++) begin
            if (rd_en1[i]) rd_data1 = rd_data1 | regs[i];
            if (rd_en2[i]) rd_data2 = rd_data2 | regs[i];
        end
    end

    int errors = 0;
    int checks = 0;

    int            got_addr[$];
    logic [DW-1:0] got_d1[$];
    logic [DW-1:0] got_d2[$];
    int            onehot_viol;
    int            done_cnt;
    int            done_cyc;
    logic [DW-1:0] cs_at_done;
    logic          busy_at_done;

    // Reference checksum: XOR of all register values, or 0 without the feature.
    function automatic logic [DW-1:0] model_checksum(input int upto);
        logic [DW-1:0] acc;
        acc = '0;
`ifdef REGDUMP_CHECKSUM_EN
        for (int i = 0; i < upto; i++) acc = acc ^ regs[i];
`endif
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs the dump from the first READ cycle and records accepted pairs.
    task automatic run_collect(input int ready_pct, input int restart_addr, input int max_cyc);
        got_addr.delete(); got_d1.delete(); got_d2.delete();
        onehot_viol = 0; done_cnt = 0; done_cyc = -1; cs_at_done = '0; busy_at_done = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if ($countones(rd_en1) > 1 || $countones(rd_en2) > 1) onehot_viol++;
            if (done) begin
                done_cnt++; done_cyc = cyc; cs_at_done = checksum; busy_at_done = busy;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            start = (restart_addr >= 0 && out_valid && int'(out_addr) == restart_addr);
            if (out_valid && out_ready) begin
                got_addr.push_back(int'(out_addr));
                got_d1.push_back(out_data1);
                got_d2.push_back(out_data2);
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (rd_en1 !== '0 || rd_en2 !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || out_addr !== '0 || out_data1 !== '0 || out_data2 !== '0 ||
            checksum !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en1=%h en2=%h v=%b busy=%b done=%b addr=%0d d1=%h d2=%h cs=%h, all required 0",
                     rd_en1, rd_en2, out_valid, busy, done, out_addr, out_data1, out_data2, checksum);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_en1 !== '0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b en1=%h required 0/0", busy, rd_en1);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle2: busy=%b valid=%b required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_full_dump();
        int n;
        for (int i = 0; i < NR; i++) regs[i] = 32'h1000 + i;
        start_pulse();
        run_collect(100, -1, 80);
        checks++;
        if (got_addr.size() != NR/2) begin
            errors++;
            $display("FAIL full_pair_count: got %0d required %0d", got_addr.size(), NR/2);
        end
        n = (got_addr.size() < NR/2) ? got_addr.size() : NR/2;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_addr[k] != 2*k || got_d1[k] !== regs[2*k] || got_d2[k] !== regs[2*k+1]) begin
                errors++;
                $display("FAIL full_pair%0d: addr=%0d d1=%h d2=%h required addr=%0d d1=%h d2=%h",
                         k, got_addr[k], got_d1[k], got_d2[k], 2*k, regs[2*k], regs[2*k+1]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != NR + 1) begin
            errors++;
            $display("FAIL full_done: count=%0d cycle=%0d required 1 at %0d", done_cnt, done_cyc, NR + 1);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_in_done: busy=%b required 0", busy_at_done);
        end
        checks++;
        if (onehot_viol != 0) begin
            errors++;
            $display("FAIL full_onehot: %0d multi-hot cycles required 0", onehot_viol);
        end
    endtask

    task automatic test_backpressure();
        int stall;
        int seen_done;
        stall = 0; seen_done = 0;
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        got_addr.delete();
        start_pulse();
        for (int cyc = 1; cyc <= 120 && seen_done == 0; cyc++) begin
            if (done) seen_done = 1;
            if (out_valid && out_addr == 5'd4 && stall < 5) begin
                stall++;
                out_ready = 1'b0;
                checks++;
                if (out_data1 !== regs[4] || out_data2 !== regs[5] || rd_en1 !== '0 || rd_en2 !== '0) begin
                    errors++;
                    $display("FAIL stall%0d: d1=%h d2=%h en1=%h en2=%h required %h %h 0 0",
                             stall, out_data1, out_data2, rd_en1, rd_en2, regs[4], regs[5]);
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) got_addr.push_back(int'(out_addr));
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (stall != 5 || seen_done == 0) begin
            errors++;
            $display("FAIL stall_count: stalls=%0d done=%0d required 5/1", stall, seen_done);
        end
        checks++;
        if (got_addr.size() < 4 || got_addr[2] != 4 || got_addr[3] != 6) begin
            errors++;
            $display("FAIL resume: accepted %0d pairs, required pair 4 then 6", got_addr.size());
        end
        checks++;
        if (got_addr.size() != NR/2) begin
            errors++;
            $display("FAIL stall_pair_count: got %0d required %0d", got_addr.size(), NR/2);
        end
    endtask

    task automatic test_random_restart();
        int n;
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        start_pulse();
        run_collect(60, 10, 600);
        checks++;
        if (got_addr.size() != NR/2 || done_cnt != 1) begin
            errors++;
            $display("FAIL rand_counts: pairs=%0d dones=%0d required %0d/1", got_addr.size(), done_cnt, NR/2);
        end
        n = (got_addr.size() < NR/2) ? got_addr.size() : NR/2;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_addr[k] != 2*k || got_d1[k] !== regs[2*k] || got_d2[k] !== regs[2*k+1]) begin
                errors++;
                $display("FAIL rand_pair%0d: addr=%0d d1=%h d2=%h required addr=%0d d1=%h d2=%h",
                         k, got_addr[k], got_d1[k], got_d2[k], 2*k, regs[2*k], regs[2*k+1]);
            end
        end
        checks++;
        if (cs_at_done !== model_checksum(NR)) begin
            errors++;
            $display("FAIL rand_checksum: got %h required %h", cs_at_done, model_checksum(NR));
        end
    endtask

    task automatic test_abort();
        int found;
        int bad_done;
        found = 0; bad_done = 0;
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        start_pulse();
        for (int cyc = 0; cyc < 60 && found == 0; cyc++) begin
            if (out_valid && out_addr == 5'd8) begin
                found = 1;
            end else begin
                out_ready = 1'b1;
                tick();
            end
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL abort_reach: pair 8 never presented");
        end
        out_ready = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en1 !== '0 || rd_en2 !== '0) begin
            errors++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b en1=%h en2=%h required all 0",
                     out_valid, busy, done, rd_en1, rd_en2);
        end
        checks++;
        if (checksum !== model_checksum(8)) begin
            errors++;
            $display("FAIL abort_checksum: got %h required %h", checksum, model_checksum(8));
        end
        for (int c = 0; c < 3; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad_done++;
            tick();
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", bad_done);
        end
        start_pulse();
        run_collect(100, -1, 80);
        checks++;
        if (got_addr.size() != NR/2 || got_addr[0] != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: pairs=%0d dones=%0d required %0d pairs from 0 and 1 done",
                     got_addr.size(), done_cnt, NR/2);
        end
    endtask

    task automatic test_async_reset();
        int found;
        found = 0;
        start_pulse();
        for (int cyc = 0; cyc < 60 && found == 0; cyc++) begin
            if (rd_en1[12]) begin
                found = 1;
            end else begin
                out_ready = 1'b1;
                tick();
            end
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL areset_reach: READ of pair 12 never seen");
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_en1 !== '0 || rd_en2 !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || checksum !== '0) begin
            errors++;
            $display("FAIL areset_drop: en1=%h en2=%h valid=%b busy=%b cs=%h required all 0",
                     rd_en1, rd_en2, out_valid, busy, checksum);
        end
        #3;
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || rd_en1 !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle: busy=%b valid=%b en1=%h done=%b required all 0",
                     busy, out_valid, rd_en1, done);
        end
    endtask

    task automatic test_checksum();
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
`ifdef REGDUMP_CHECKSUM_EN
        exp_a = 32'h0000_0000;
        exp_b = 32'hFFFF_0000;
`else
        exp_a = 32'h0000_0000;
        exp_b = 32'h0000_0000;
`endif
        for (int i = 0; i < NR; i++) regs[i] = i;
        start_pulse();
        run_collect(100, -1, 80);
        checks++;
        if (cs_at_done !== exp_a || cs_at_done !== model_checksum(NR)) begin
            errors++;
            $display("FAIL checksum_identity: got %h required %h", cs_at_done, exp_a);
        end
        regs[5] = 32'hFFFF_0005;
        start_pulse();
        run_collect(70, -1, 200);
        checks++;
        if (cs_at_done !== exp_b || cs_at_done !== model_checksum(NR)) begin
            errors++;
            $display("FAIL checksum_reg5: got %h required %h", cs_at_done, exp_b);
        end
        checks++;
        if (checksum !== exp_b) begin
            errors++;
            $display("FAIL checksum_hold: got %h required %h", checksum, exp_b);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = '0;
        test_reset();
        test_start_abort_idle();
        test_full_dump();
        test_backpressure();
        test_random_restart();
        test_abort();
        test_async_reset();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
